// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Pipelined main-decoder / control unit for a 5-stage core.
//               Decodes the ID-stage opcode into EX/MEM/WB control words and
//               carries them through the ID/EX, EX/MEM and MEM/WB registers.
//               Generates the load-use stall, branch/jump flush and the
//               data-memory wait freeze.
// Ports       : clk, reset (async, active-high)
//               id_*            : IF/ID instruction fields and valid
//               ex_branch_taken : EX resolved a taken branch/jump
//               mem_ready       : data memory completes its access this cycle
//               stall_if_id / flush_if_id / illegal_op : combinational
//               ex_* / mem_* / wb_* : registered stage control words
// Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  illegal_op,
    output logic                  ex_valid,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_RW    = 7'b0111011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_IW    = 7'b0011011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    // ---------------------------------------------------------------- decode
    logic                  w_legal;
    logic                  w_rs1_used;
    logic                  w_rs2_used;
    logic                  w_alu_src;
    logic                  w_reg_write;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_branch;
    logic                  w_jump;
    logic [1:0]            w_mem_to_reg;
    logic [ALUOP_W-1:0]    w_alu_op;
    logic [REG_ADDR_W-1:0] w_rd;

    // Fields stay zero unless id_valid carries a legal opcode, so the decoded
    // word is already a bubble for empty or illegal instructions.
    always_comb begin
        w_legal      = 1'b0;
        w_rs1_used   = 1'b0;
        w_rs2_used   = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_mem_to_reg = 2'b00;
        w_alu_op     = '0;
        if (id_valid) begin
            unique case (id_opcode)
                c_OP_R, c_OP_RW: begin
                    w_legal = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                    w_reg_write = 1'b1; w_alu_op[1:0] = 2'b10;
                end
                c_OP_I, c_OP_IW: begin
                    w_legal = 1'b1; w_rs1_used = 1'b1;
                    w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op[1:0] = 2'b11;
                end
                c_OP_LOAD: begin
                    w_legal = 1'b1; w_rs1_used = 1'b1;
                    w_alu_src = 1'b1; w_reg_write = 1'b1; w_mem_read = 1'b1;
                    w_mem_to_reg = 2'b01;
                end
                c_OP_STORE: begin
                    w_legal = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                    w_alu_src = 1'b1; w_mem_write = 1'b1;
                end
                c_OP_BR: begin
                    w_legal = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                    w_branch = 1'b1; w_alu_op[1:0] = 2'b01;
                end
                c_OP_JAL: begin
                    w_legal = 1'b1;
                    w_reg_write = 1'b1; w_jump = 1'b1; w_mem_to_reg = 2'b10;
                end
                c_OP_JALR: begin
                    w_legal = 1'b1; w_rs1_used = 1'b1;
                    w_alu_src = 1'b1; w_reg_write = 1'b1; w_jump = 1'b1;
                    w_mem_to_reg = 2'b10;
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_rd = w_legal ? id_rd : '0;

    // ---------------------------------------------------------- stage regs
    logic                  r_ex_valid, r_ex_alu_src, r_ex_branch, r_ex_jump;
    logic                  r_ex_reg_write, r_ex_mem_read, r_ex_mem_write;
    logic [1:0]            r_ex_mem_to_reg;
    logic [ALUOP_W-1:0]    r_ex_alu_op;
    logic [REG_ADDR_W-1:0] r_ex_rd;

    logic                  r_mem_valid, r_mem_reg_write, r_mem_read, r_mem_write;
    logic [1:0]            r_mem_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_mem_rd;

    logic                  r_wb_valid, r_wb_reg_write;
    logic [1:0]            r_wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    // ------------------------------------------------------------- hazards
    logic w_freeze;
    logic w_flush;
    logic w_loaduse;

    assign w_freeze  = r_mem_valid & (r_mem_read | r_mem_write) & ~mem_ready;
    assign w_flush   = r_ex_valid & (r_ex_branch | r_ex_jump) & ex_branch_taken;
    assign w_loaduse = id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != '0) &
                       (((r_ex_rd == id_rs1) & w_rs1_used) |
                        ((r_ex_rd == id_rs2) & w_rs2_used));

    // Gated with reset so the combinational outputs read 0 while reset is high.
    assign stall_if_id = ~reset & (w_freeze | (~w_flush & w_loaduse));
    assign flush_if_id = ~reset & ~w_freeze & w_flush;
    assign illegal_op  = ~reset & id_valid & ~w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid  <= 1'b0; r_ex_alu_src   <= 1'b0; r_ex_branch    <= 1'b0;
            r_ex_jump   <= 1'b0; r_ex_reg_write <= 1'b0; r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0; r_ex_mem_to_reg <= 2'b00;
            r_ex_alu_op <= '0;   r_ex_rd <= '0;
            r_mem_valid <= 1'b0; r_mem_reg_write <= 1'b0; r_mem_read <= 1'b0;
            r_mem_write <= 1'b0; r_mem_mem_to_reg <= 2'b00; r_mem_rd <= '0;
            r_wb_valid  <= 1'b0; r_wb_reg_write <= 1'b0;
            r_wb_mem_to_reg <= 2'b00; r_wb_rd <= '0;
        end else if (w_freeze) begin
            // ID/EX and EX/MEM hold; the stalled access must not retire.
            r_wb_valid  <= 1'b0; r_wb_reg_write <= 1'b0;
            r_wb_mem_to_reg <= 2'b00; r_wb_rd <= '0;
        end else begin
            r_wb_valid      <= r_mem_valid;
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_to_reg <= r_mem_mem_to_reg;
            r_wb_rd         <= r_mem_rd;

            r_mem_valid      <= r_ex_valid;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_read       <= r_ex_mem_read;
            r_mem_write      <= r_ex_mem_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_rd         <= r_ex_rd;

            if (w_flush || w_loaduse) begin
                r_ex_valid  <= 1'b0; r_ex_alu_src   <= 1'b0; r_ex_branch    <= 1'b0;
                r_ex_jump   <= 1'b0; r_ex_reg_write <= 1'b0; r_ex_mem_read  <= 1'b0;
                r_ex_mem_write <= 1'b0; r_ex_mem_to_reg <= 2'b00;
                r_ex_alu_op <= '0;   r_ex_rd <= '0;
            end else begin
                r_ex_valid      <= w_legal;
                r_ex_alu_src    <= w_alu_src;
                r_ex_branch     <= w_branch;
                r_ex_jump       <= w_jump;
                r_ex_reg_write  <= w_reg_write;
                r_ex_mem_read   <= w_mem_read;
                r_ex_mem_write  <= w_mem_write;
                r_ex_mem_to_reg <= w_mem_to_reg;
                r_ex_alu_op     <= w_alu_op;
                r_ex_rd         <= w_rd;
            end
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_alu_src    = r_ex_alu_src;
    assign ex_branch     = r_ex_branch;
    assign ex_jump       = r_ex_jump;
    assign ex_alu_op     = r_ex_alu_op;
    assign ex_rd         = r_ex_rd;
    assign mem_valid     = r_mem_valid;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_rd        = r_mem_rd;
    assign wb_valid      = r_wb_valid;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_rd         = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Self-checking bench for pipe_ctrl_unit. Directed hazard
//               sequences followed by randomized instruction streams, every
//               cycle compared against a table-driven pipeline model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, mem_ready;
    logic       stall_if_id, flush_if_id, illegal_op;
    logic       ex_valid, ex_alu_src, ex_branch, ex_jump;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_read, mem_write;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_reg_write;
    logic [1:0] wb_mem_to_reg;
    logic [4:0] wb_rd;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .ALUOP_W(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .illegal_op(illegal_op),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    // ----------------------------------------------------------------- model
    typedef struct packed {
        bit       v;
        bit       alu_src, reg_write, mem_read, mem_write, branch, jump;
        bit [1:0] m2r, aluop;
        bit [4:0] rd;
    } ctl_t;

    ctl_t m_ex, m_mem, m_wb;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Control word straight from the opcode table:
    // {alu_src,reg_write,mem_read,mem_write,branch,jump,mem_to_reg,alu_op}
    function automatic bit [9:0] tbl(input bit [6:0] op, output bit ok);
        ok = 1'b1;
        case (op)
            7'b0110011, 7'b0111011: tbl = 10'b0_1_0_0_0_0_00_10;
            7'b0010011, 7'b0011011: tbl = 10'b1_1_0_0_0_0_00_11;
            7'b0000011:             tbl = 10'b1_1_1_0_0_0_01_00;
            7'b0100011:             tbl = 10'b1_0_0_1_0_0_00_00;
            7'b1100011:             tbl = 10'b0_0_0_0_1_0_00_01;
            7'b1101111:             tbl = 10'b0_1_0_0_0_1_10_00;
            7'b1100111:             tbl = 10'b1_1_0_0_0_1_10_00;
            default: begin tbl = 10'b0; ok = 1'b0; end
        endcase
    endfunction

    function automatic ctl_t ref_decode(input bit v, input bit [6:0] op, input bit [4:0] rd);
        ctl_t c;
        bit ok;
        bit [9:0] w;
        c = '0;
        w = tbl(op, ok);
        if (v && ok) begin
            {c.alu_src, c.reg_write, c.mem_read, c.mem_write, c.branch, c.jump,
             c.m2r, c.aluop} = w;
            c.v  = 1'b1;
            c.rd = rd;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected hazard signals from the model state and current ID inputs.
    bit e_freeze, e_flush, e_lu;

    task automatic compute_hazards();
        bit ok, u1, u2;
        bit [9:0] w;
        w  = tbl(id_opcode, ok);
        u1 = ok && (id_opcode != 7'b1101111);
        u2 = ok && (w[5] || w[6] || (id_opcode == 7'b0110011) || (id_opcode == 7'b0111011));
        e_freeze = m_mem.v && (m_mem.mem_read || m_mem.mem_write) && !mem_ready;
        e_flush  = m_ex.v && (m_ex.branch || m_ex.jump) && ex_branch_taken;
        e_lu     = id_valid && m_ex.v && m_ex.mem_read && (m_ex.rd != 0) &&
                   ((m_ex.rd == id_rs1 && u1) || (m_ex.rd == id_rs2 && u2));
    endtask

    task automatic compare_all(input bit in_rst);
        bit ok;
        bit [9:0] w;
        w = tbl(id_opcode, ok);
        compute_hazards();
        check("stall",   stall_if_id, in_rst ? 0 : (e_freeze || (!e_flush && e_lu)));
        check("flush",   flush_if_id, in_rst ? 0 : (!e_freeze && e_flush));
        check("illegal", illegal_op,  in_rst ? 0 : (id_valid && !ok));
        check("ex_valid",   ex_valid,   m_ex.v);
        check("ex_alu_src", ex_alu_src, m_ex.alu_src);
        check("ex_branch",  ex_branch,  m_ex.branch);
        check("ex_jump",    ex_jump,    m_ex.jump);
        check("ex_alu_op",  ex_alu_op,  m_ex.aluop);
        check("ex_rd",      ex_rd,      m_ex.rd);
        check("mem_valid",  mem_valid,  m_mem.v);
        check("mem_read",   mem_read,   m_mem.mem_read);
        check("mem_write",  mem_write,  m_mem.mem_write);
        check("mem_rd",     mem_rd,     m_mem.rd);
        check("wb_valid",   wb_valid,   m_wb.v);
        check("wb_reg_write",  wb_reg_write,  m_wb.reg_write);
        check("wb_mem_to_reg", wb_mem_to_reg, m_wb.m2r);
        check("wb_rd",      wb_rd,      m_wb.rd);
    endtask

    // Called at posedge+1: drive, optional async reset pulse, check at negedge,
    // advance the model, return at the following posedge+1.
    task automatic do_cycle(input bit v, input bit [6:0] op, input bit [4:0] s1,
                            input bit [4:0] s2, input bit [4:0] d, input bit tk,
                            input bit rdy, input bit rstp);
        id_valid = v; id_opcode = op; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        ex_branch_taken = tk; mem_ready = rdy;
        if (rstp) begin
            #1 reset = 1'b1;
            m_ex = '0; m_mem = '0; m_wb = '0;
            #1 compare_all(1'b1);
            #1 reset = 1'b0;
        end
        @(negedge clk);
        compare_all(1'b0);
        compute_hazards();
        if (e_freeze) begin
            m_wb = '0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e_flush || e_lu) ? ctl_t'('0) : ref_decode(v, op, d);
        end
        @(posedge clk);
        #1;
    endtask

    localparam bit [6:0] c_ADD = 7'b0110011, c_LW = 7'b0000011, c_SW = 7'b0100011;
    localparam bit [6:0] c_BEQ = 7'b1100011, c_JAL = 7'b1101111, c_ADDI = 7'b0010011;

    bit [6:0] ops [9];

    initial begin
        ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011,
                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        m_ex = '0; m_mem = '0; m_wb = '0;
        reset = 1'b1; id_valid = 1'b1; id_opcode = 7'b1111111;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_branch_taken = 1'b1; mem_ready = 1'b0;
        #12 compare_all(1'b1);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // add x3,x1,x2 then drain
        do_cycle(1, c_ADD, 1, 2, 3, 0, 1, 0);
        repeat (3) do_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        // lw x5 ; add rs1=5 (held in IF/ID across the stall)
        do_cycle(1, c_LW, 1, 0, 5, 0, 1, 0);
        do_cycle(1, c_ADD, 5, 2, 6, 0, 1, 0);
        do_cycle(1, c_ADD, 5, 2, 6, 0, 1, 0);
        // lw x0 ; add rs1=0  -> no stall
        do_cycle(1, c_LW, 1, 0, 0, 0, 1, 0);
        do_cycle(1, c_ADD, 0, 2, 6, 0, 1, 0);
        // lw x5 ; sw rs2=5 -> stall
        do_cycle(1, c_LW, 1, 0, 5, 0, 1, 0);
        do_cycle(1, c_SW, 1, 5, 9, 0, 1, 0);
        do_cycle(1, c_SW, 1, 5, 9, 0, 1, 0);
        // lw x5 ; jal (rs fields 5) -> no stall
        do_cycle(1, c_LW, 1, 0, 5, 0, 1, 0);
        do_cycle(1, c_JAL, 5, 5, 1, 0, 1, 0);
        // beq resolved taken while add sits in ID
        do_cycle(1, c_BEQ, 1, 2, 7, 0, 1, 0);
        do_cycle(1, c_ADD, 1, 2, 4, 1, 1, 0);
        do_cycle(1, c_ADD, 1, 2, 4, 0, 1, 0);
        // sw reaches MEM, memory waits three cycles
        do_cycle(1, c_SW, 1, 2, 0, 0, 1, 0);
        do_cycle(1, c_ADDI, 3, 0, 8, 0, 1, 0);
        repeat (3) do_cycle(1, c_ADD, 1, 2, 4, 0, 0, 0);
        do_cycle(1, c_ADD, 1, 2, 4, 0, 1, 0);
        // illegal opcode
        do_cycle(1, 7'b1111111, 1, 2, 3, 0, 1, 0);
        // reset with lw in MEM and memory waiting
        do_cycle(1, c_LW, 1, 0, 5, 0, 1, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        do_cycle(1, c_ADD, 1, 2, 3, 1, 0, 1);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Randomized streams: small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            bit [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            do_cycle($urandom_range(0, 4) != 0, op,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 1'($urandom),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
